// File: rtl/icache_refill_ctrl_if.sv
// Cache-side and memory-side signals of the instruction-cache refill controller.
// The master modport is the controller; the slave modport is the cache plus memory.
interface icache_refill_ctrl_if;
    logic        miss;
    logic [31:0] fetchaddr;
    logic [31:0] ifetch;
    logic        iready;
    logic        busy;
    logic        refill_done;
    logic        timeout_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  miss, fetchaddr, mem_rdata, mem_ack,
        output ifetch, iready, busy, refill_done, timeout_err, mem_req, mem_addr
    );

    modport slave (
        output miss, fetchaddr, mem_rdata, mem_ack,
        input  ifetch, iready, busy, refill_done, timeout_err, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Refills one direct-mapped I-cache block from memory, word 0 upward, over req/ack.
// state   | meaning
// IDLE    | waiting for miss; latches block base on miss
// REQ     | mem_req held with stable mem_addr until ack or wait timer expiry
// DELIVER | iready pulse, ifetch carries the word captured on ack
// GAP     | spacer cycle; advance to next word or finish
// DONE    | refill_done pulse, miss ignored
module icache_refill_ctrl #(
    parameter int WORDSPERBLOCK = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    icache_refill_ctrl_if.master bus
);
    localparam int          WCW       = $clog2(WORDSPERBLOCK);
    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [31:0] BLK_MASK  = ~(32'(WORDSPERBLOCK * 4) - 32'd1);
    localparam logic [WCW-1:0] WC_LAST = WCW'(WORDSPERBLOCK - 1);
    localparam logic [TW-1:0]  WT_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DELIVER,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    base_q, base_d;
    logic [WCW-1:0] wc_q, wc_d;
    logic [TW-1:0]  wt_q, wt_d;
    logic [31:0]    ifetch_q, ifetch_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic           iready_q, iready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           terr_q, terr_d;
    logic           mem_req_q, mem_req_d;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wc_d       = wc_q;
        wt_d       = wt_q;
        ifetch_d   = ifetch_q;
        mem_addr_d = mem_addr_q;
        iready_d   = 1'b0;
        done_d     = 1'b0;
        terr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.miss) begin
                    base_d     = bus.fetchaddr & BLK_MASK;
                    mem_addr_d = bus.fetchaddr & BLK_MASK;
                    wc_d       = '0;
                    wt_d       = WT_LOAD;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    ifetch_d = bus.mem_rdata;
                    iready_d = 1'b1;
                    state_d  = S_DELIVER;
                end else if (wt_q == '0) begin
                    // Wait timer is a down-counter; zero means TIMEOUT unacked cycles.
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wt_d = wt_q - 1'b1;
                end
            end
            S_DELIVER: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (wc_q == WC_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wc_d       = wc_q + 1'b1;
                    wt_d       = WT_LOAD;
                    mem_addr_d = base_q | (32'(wc_d) << 2);
                    state_d    = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            wc_q       <= '0;
            wt_q       <= '0;
            ifetch_q   <= '0;
            mem_addr_q <= '0;
            iready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wc_q       <= wc_d;
            wt_q       <= wt_d;
            ifetch_q   <= ifetch_d;
            mem_addr_q <= mem_addr_d;
            iready_q   <= iready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign bus.ifetch      = ifetch_q;
    assign bus.iready      = iready_q;
    assign bus.busy        = busy_q;
    assign bus.refill_done = done_q;
    assign bus.timeout_err = terr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: reset, zero-wait, wait states,
// address change mid-refill, timeout and reset during delivery.
module tb_icache_refill_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   start_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    icache_refill_ctrl_if bus ();

    icache_refill_ctrl #(.WORDSPERBLOCK(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first REQ cycle of a word; leaves after its GAP cycle.
    task automatic do_word(input logic [31:0] a, input int waits);
        for (int w = 0; w <= waits; w++) begin
            chk("req_high", 32'(bus.mem_req), 32'd1);
            chk("req_addr", bus.mem_addr, a);
            chk("no_iready_in_req", 32'(bus.iready), 32'd0);
            chk("no_early_done", 32'(bus.refill_done), 32'd0);
            bus.mem_ack   = (w == waits);
            bus.mem_rdata = (w == waits) ? (32'hAA000000 | a) : 32'hDEAD0000;
            step();
        end
        // Ack during DELIVER must be ignored.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
        chk("deliver_iready", 32'(bus.iready), 32'd1);
        chk("deliver_ifetch", bus.ifetch, 32'hAA000000 | a);
        chk("deliver_req_low", 32'(bus.mem_req), 32'd0);
        chk("deliver_busy", 32'(bus.busy), 32'd1);
        step();
        bus.mem_ack = 1'b0;
        chk("gap_iready_low", 32'(bus.iready), 32'd0);
        chk("gap_ifetch_hold", bus.ifetch, 32'hAA000000 | a);
        chk("gap_req_low", 32'(bus.mem_req), 32'd0);
        step();
    endtask

    task automatic chk_done(input int exp_len);
        chk("done_pulse", 32'(bus.refill_done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_req_low", 32'(bus.mem_req), 32'd0);
        chk("refill_len", 32'(cyc - start_cyc), 32'(exp_len));
        bus.miss = 1'b0;
        step();
        chk("after_done_pulse", 32'(bus.refill_done), 32'd0);
        chk("after_done_busy", 32'(bus.busy), 32'd0);
        step();
        chk("idle_no_retrigger", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with miss and ack active.
        reset         = 1'b1;
        bus.miss      = 1'b1;
        bus.fetchaddr = 32'h00000014;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_req", 32'(bus.mem_req), 32'd0);
            chk("rst_iready", 32'(bus.iready), 32'd0);
            chk("rst_done", 32'(bus.refill_done), 32'd0);
            chk("rst_terr", 32'(bus.timeout_err), 32'd0);
            chk("rst_addr", bus.mem_addr, 32'd0);
            chk("rst_ifetch", bus.ifetch, 32'd0);
        end
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        step();
        start_cyc = cyc;
        chk("first_req_after_rst", 32'(bus.mem_req), 32'd1);
        chk("first_busy", 32'(bus.busy), 32'd1);

        // Zero-wait refill of block 0x10.
        do_word(32'h10, 0);
        do_word(32'h14, 0);
        do_word(32'h18, 0);
        do_word(32'h1C, 0);
        chk_done(12);

        // Three wait states per word, fetchaddr moves after the first word.
        bus.miss      = 1'b1;
        bus.fetchaddr = 32'h00000108;
        step();
        start_cyc = cyc;
        do_word(32'h100, 3);
        bus.fetchaddr = 32'h00000200;
        do_word(32'h104, 3);
        do_word(32'h108, 3);
        do_word(32'h10C, 3);
        chk_done(24);

        // Timeout: memory never acks, miss stays high.
        bus.miss      = 1'b1;
        bus.fetchaddr = 32'h000003C4;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("to_req_high", 32'(bus.mem_req), 32'd1);
            chk("to_addr", bus.mem_addr, 32'h3C0);
            chk("to_no_iready", 32'(bus.iready), 32'd0);
            chk("to_no_err_yet", 32'(bus.timeout_err), 32'd0);
            step();
        end
        chk("to_err_pulse", 32'(bus.timeout_err), 32'd1);
        chk("to_err_req_low", 32'(bus.mem_req), 32'd0);
        chk("to_err_idle", 32'(bus.busy), 32'd0);
        chk("to_err_no_iready", 32'(bus.iready), 32'd0);
        step();
        chk("to_retry_req", 32'(bus.mem_req), 32'd1);
        chk("to_retry_addr", bus.mem_addr, 32'h3C0);
        chk("to_err_cleared", 32'(bus.timeout_err), 32'd0);

        // Reset while iready is high.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hAA0003C0;
        step();
        bus.mem_ack = 1'b0;
        chk("pre_rst_iready", 32'(bus.iready), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_iready", 32'(bus.iready), 32'd0);
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ifetch", bus.ifetch, 32'd0);
        step();
        step();
        reset         = 1'b0;
        bus.fetchaddr = 32'h000003C8;
        step();
        start_cyc = cyc;
        do_word(32'h3C0, 0);
        do_word(32'h3C4, 0);
        do_word(32'h3C8, 0);
        do_word(32'h3CC, 0);
        chk_done(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
